div_seq_32: RTL

//   Iterative radix-2 restoring divider for MIPS DIV/DIVU; complements the lookahead adder

---
 rtl/div_seq_32.sv | 109 ++++++++++
 1 files changed

// File: rtl/div_seq_32.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Produces one quotient bit per clock; HI = remainder, LO = quotient.
module div_seq_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs_mag, dvd_raw;
  logic             sgn_q, sgn_r, op_signed, dvs_zero;

  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   shifted, trial;

  always_comb begin
    dvd_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_abs = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    // trial[WIDTH] is the borrow: set when the shifted remainder is below the divisor
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_mag};
  end

  assign busy = (state == S_RUN) || (state == S_FIX);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs_mag   <= '0;
      dvd_raw   <= '0;
      sgn_q     <= 1'b0;
      sgn_r     <= 1'b0;
      op_signed <= 1'b0;
      dvs_zero  <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rem       <= '0;
            quo       <= dvd_abs;
            dvs_mag   <= dvs_abs;
            dvd_raw   <= dividend;
            sgn_q     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sgn_r     <= dividend[WIDTH-1];
            op_signed <= is_signed;
            dvs_zero  <= (divisor == '0);
            cnt       <= CW'(WIDTH);
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (cancel) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
            cnt <= cnt - CW'(1);
          end
        end
        S_FIX: begin
          if (cancel) begin
            state <= S_IDLE;
          end else begin
            // Zero divisor reports the raw dividend, not its magnitude
            if (dvs_zero) begin
              quotient  <= '1;
              remainder <= dvd_raw;
            end else begin
              quotient  <= (op_signed && sgn_q) ? -quo : quo;
              remainder <= (op_signed && sgn_r) ? -rem : rem;
            end
            div_zero <= dvs_zero;
            state    <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
